// File: rtl/painterengine_gpu_framefetch_pkg.sv
`default_nettype none
// =============================================================================
// Module      : painterengine_gpu_framefetch_pkg
// Description : Frame fetch state encodings, pixel-size codes and status word
//               layout shared by the fetch scheduler and its address generator.
// Revision    : 1.0 - initial release
// =============================================================================
package painterengine_gpu_framefetch_pkg;

    localparam logic [3:0] FETCH_STATE_IDLE       = 4'd0;
    localparam logic [3:0] FETCH_STATE_LATCH      = 4'd1;
    localparam logic [3:0] FETCH_STATE_CALC       = 4'd2;
    localparam logic [3:0] FETCH_STATE_WAIT_SPACE = 4'd3;
    localparam logic [3:0] FETCH_STATE_STREAM     = 4'd4;
    localparam logic [3:0] FETCH_STATE_ADVANCE    = 4'd5;
    localparam logic [3:0] FETCH_STATE_DONE       = 4'd6;
    localparam logic [3:0] FETCH_STATE_ERROR      = 4'd7;

    localparam logic BPP_SEL_4B = 1'b0;
    localparam logic BPP_SEL_2B = 1'b1;

    typedef struct packed {
        logic [21:0] reserved;
        logic [2:0]  retry_cnt;
        logic        busy;
        logic        error;
        logic        frame_done_sticky;
        logic [3:0]  state;
    } fetch_status_t;

    // Byte offset of a pixel index is index << shift.
    function automatic logic [1:0] pixel_shift(input logic bpp_sel);
        logic [1:0] shift;
        case (bpp_sel)
            BPP_SEL_2B: shift = 2'd1;
            BPP_SEL_4B: shift = 2'd2;
            default:    shift = 2'd2;
        endcase
        return shift;
    endfunction

endpackage
`default_nettype wire

// File: rtl/painterengine_gpu_framefetch_if.sv
`default_nettype none
// =============================================================================
// Module      : painterengine_gpu_framefetch_if
// Description : Burst command / completion handshake between the frame fetch
//               scheduler (master) and the DMA reader (slave).
// Revision    : 1.0 - initial release
// =============================================================================
interface painterengine_gpu_framefetch_if;

    logic [31:0] o_wire_reader_address;
    logic [31:0] o_wire_reader_length;
    logic        o_wire_reader_resetn;
    logic        i_wire_reader_done;
    logic        i_wire_reader_error;

    modport master (
        output o_wire_reader_address,
        output o_wire_reader_length,
        output o_wire_reader_resetn,
        input  i_wire_reader_done,
        input  i_wire_reader_error
    );

    modport slave (
        input  o_wire_reader_address,
        input  o_wire_reader_length,
        input  o_wire_reader_resetn,
        output i_wire_reader_done,
        output i_wire_reader_error
    );

endinterface
`default_nettype wire

// File: rtl/painterengine_gpu_framefetch_addrgen.sv
`default_nettype none
// =============================================================================
// Module      : painterengine_gpu_framefetch_addrgen
// Description : Line base / x / y counters with stride accumulation; produces
//               the start address and pixel length of each reader burst.
// Revision    : 1.0 - initial release
// =============================================================================
module painterengine_gpu_framefetch_addrgen #(
    parameter int BLOCK_SIZE = 64
) (
    input  logic        i_wire_clock,
    input  logic        i_wire_resetn,
    input  logic        i_wire_latch,
    input  logic        i_wire_load_burst,
    input  logic        i_wire_burst_done,
    input  logic        i_wire_advance,
    input  logic [31:0] i_wire_image_address,
    input  logic [31:0] i_wire_stride_bytes,
    input  logic [15:0] i_wire_clip_width,
    input  logic [15:0] i_wire_clip_height,
    input  logic        i_wire_bpp_sel,
    output logic [31:0] o_wire_burst_address,
    output logic [31:0] o_wire_burst_length,
    output logic        o_wire_line_end,
    output logic        o_wire_frame_end
);
    import painterengine_gpu_framefetch_pkg::*;

    localparam logic [15:0] c_block_size = 16'(BLOCK_SIZE);

    logic [31:0] r_line_base;
    logic [31:0] r_stride;
    logic [15:0] r_width;
    logic [15:0] r_height;
    logic        r_bpp_sel;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [31:0] r_burst_address;
    logic [31:0] r_burst_length;

    logic [15:0] w_remaining;
    logic [15:0] w_chunk;
    logic [31:0] w_pixel_offset;

    always_comb begin
        w_remaining    = r_width - r_x;
        w_chunk        = (w_remaining < c_block_size) ? w_remaining : c_block_size;
        w_pixel_offset = {16'd0, r_x} << pixel_shift(r_bpp_sel);
    end

    // Frame end is judged on the line being finished, before y is bumped.
    assign o_wire_line_end      = (r_x == r_width);
    assign o_wire_frame_end     = (({1'b0, r_y} + 17'd1) == {1'b0, r_height});
    assign o_wire_burst_address = r_burst_address;
    assign o_wire_burst_length  = r_burst_length;

    always_ff @(posedge i_wire_clock) begin
        if (!i_wire_resetn) begin
            r_line_base     <= 32'd0;
            r_stride        <= 32'd0;
            r_width         <= 16'd0;
            r_height        <= 16'd0;
            r_bpp_sel       <= 1'b0;
            r_x             <= 16'd0;
            r_y             <= 16'd0;
            r_burst_address <= 32'd0;
            r_burst_length  <= 32'd0;
        end else if (i_wire_latch) begin
            r_line_base <= i_wire_image_address;
            r_stride    <= i_wire_stride_bytes;
            r_width     <= i_wire_clip_width;
            r_height    <= i_wire_clip_height;
            r_bpp_sel   <= i_wire_bpp_sel;
            r_x         <= 16'd0;
            r_y         <= 16'd0;
        end else begin
            if (i_wire_load_burst) begin
                r_burst_address <= r_line_base + w_pixel_offset;
                r_burst_length  <= {16'd0, w_chunk};
            end
            if (i_wire_burst_done) begin
                r_x <= r_x + r_burst_length[15:0];
            end
            if (i_wire_advance && o_wire_line_end) begin
                r_x         <= 16'd0;
                r_y         <= r_y + 16'd1;
                r_line_base <= r_line_base + r_stride;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/painterengine_gpu_framefetch.sv
`default_nettype none
// =============================================================================
// Module      : painterengine_gpu_framefetch
// Description : Schedules DMA reader bursts copying a clipped WxH rectangle
//               into the pixel FIFO, with retry, abort and per-frame restart.
// Revision    : 1.0 - initial release
// =============================================================================
module painterengine_gpu_framefetch #(
    parameter int BLOCK_SIZE       = 64,
    parameter int FIFO_COUNT_WIDTH = 8,
    parameter int MAX_RETRY        = 2
) (
    input  logic                        i_wire_clock,
    input  logic                        i_wire_resetn,
    input  logic                        i_wire_start,
    input  logic                        i_wire_abort,
    input  logic                        i_wire_continuous,
    input  logic                        i_wire_frame_sync,
    input  logic [31:0]                 i_wire_image_address,
    input  logic [31:0]                 i_wire_stride_bytes,
    input  logic [15:0]                 i_wire_clip_width,
    input  logic [15:0]                 i_wire_clip_height,
    input  logic                        i_wire_bpp_sel,
    input  logic [FIFO_COUNT_WIDTH-1:0] i_wire_fifo_free_count,
    painterengine_gpu_framefetch_if.master io_wire_reader,
    output logic                        o_wire_frame_done,
    output logic [31:0]                 o_wire_state
);
    import painterengine_gpu_framefetch_pkg::*;

    localparam logic [2:0] c_max_retry = 3'(MAX_RETRY);

    logic [3:0]  r_state;
    logic        r_reader_resetn;
    logic        r_frame_done;
    logic        r_frame_done_sticky;
    logic        r_error_sticky;
    logic [2:0]  r_retry_cnt;

    logic [3:0]  w_state_next;
    logic        w_restart;
    logic        w_empty;
    logic        w_space_ok;
    logic        w_latch;
    logic        w_load_burst;
    logic        w_burst_done;
    logic        w_advance;
    logic        w_frame_done_next;
    logic        w_retry_inc;
    logic        w_retry_clr;
    logic        w_line_end;
    logic        w_frame_end;
    logic [31:0] w_burst_address;
    logic [31:0] w_burst_length;
    fetch_status_t w_status;

    painterengine_gpu_framefetch_addrgen #(
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_addrgen (
        .i_wire_clock         (i_wire_clock),
        .i_wire_resetn        (i_wire_resetn),
        .i_wire_latch         (w_latch),
        .i_wire_load_burst    (w_load_burst),
        .i_wire_burst_done    (w_burst_done),
        .i_wire_advance       (w_advance),
        .i_wire_image_address (i_wire_image_address),
        .i_wire_stride_bytes  (i_wire_stride_bytes),
        .i_wire_clip_width    (i_wire_clip_width),
        .i_wire_clip_height   (i_wire_clip_height),
        .i_wire_bpp_sel       (i_wire_bpp_sel),
        .o_wire_burst_address (w_burst_address),
        .o_wire_burst_length  (w_burst_length),
        .o_wire_line_end      (w_line_end),
        .o_wire_frame_end     (w_frame_end)
    );

    assign w_empty    = (i_wire_clip_width == 16'd0) || (i_wire_clip_height == 16'd0);
    assign w_space_ok = (32'(i_wire_fifo_free_count) >= w_burst_length);
    assign w_restart  = ((r_state == FETCH_STATE_IDLE) && i_wire_start) ||
                        ((r_state == FETCH_STATE_DONE) && i_wire_continuous && i_wire_frame_sync);

    always_comb begin
        w_state_next      = r_state;
        w_latch           = 1'b0;
        w_load_burst      = 1'b0;
        w_burst_done      = 1'b0;
        w_advance         = 1'b0;
        w_frame_done_next = 1'b0;
        w_retry_inc       = 1'b0;
        w_retry_clr       = 1'b0;
        case (r_state)
            FETCH_STATE_IDLE: ;
            // Address/length are refreshed in both LATCH and CALC so CALC also
            // serves the path back from ADVANCE.
            FETCH_STATE_LATCH: begin
                w_load_burst = 1'b1;
                w_state_next = FETCH_STATE_CALC;
            end
            FETCH_STATE_CALC: begin
                w_load_burst = 1'b1;
                w_state_next = FETCH_STATE_WAIT_SPACE;
            end
            FETCH_STATE_WAIT_SPACE: begin
                if (w_space_ok) w_state_next = FETCH_STATE_STREAM;
            end
            FETCH_STATE_STREAM: begin
                if (io_wire_reader.i_wire_reader_error) begin
                    if (r_retry_cnt < c_max_retry) begin
                        w_retry_inc  = 1'b1;
                        w_state_next = FETCH_STATE_WAIT_SPACE;
                    end else begin
                        w_state_next = FETCH_STATE_ERROR;
                    end
                end else if (io_wire_reader.i_wire_reader_done) begin
                    w_burst_done = 1'b1;
                    w_retry_clr  = 1'b1;
                    w_state_next = FETCH_STATE_ADVANCE;
                end
            end
            FETCH_STATE_ADVANCE: begin
                w_advance = 1'b1;
                if (w_line_end && w_frame_end) begin
                    w_state_next      = FETCH_STATE_DONE;
                    w_frame_done_next = 1'b1;
                end else begin
                    w_state_next = FETCH_STATE_CALC;
                end
            end
            FETCH_STATE_DONE: begin
                if (!i_wire_continuous) w_state_next = FETCH_STATE_IDLE;
            end
            FETCH_STATE_ERROR: ;
            default: w_state_next = FETCH_STATE_IDLE;
        endcase

        if (w_restart) begin
            w_latch     = 1'b1;
            w_retry_clr = 1'b1;
            if (w_empty) begin
                w_state_next      = FETCH_STATE_DONE;
                w_frame_done_next = 1'b1;
            end else begin
                w_state_next = FETCH_STATE_LATCH;
            end
        end

        // Abort overrides every other request in the same cycle.
        if (i_wire_abort) begin
            w_state_next      = FETCH_STATE_IDLE;
            w_latch           = 1'b0;
            w_load_burst      = 1'b0;
            w_burst_done      = 1'b0;
            w_advance         = 1'b0;
            w_frame_done_next = 1'b0;
            w_retry_inc       = 1'b0;
            w_retry_clr       = 1'b1;
        end
    end

    always_ff @(posedge i_wire_clock) begin
        if (!i_wire_resetn) begin
            r_state             <= FETCH_STATE_IDLE;
            r_reader_resetn     <= 1'b0;
            r_frame_done        <= 1'b0;
            r_frame_done_sticky <= 1'b0;
            r_error_sticky      <= 1'b0;
            r_retry_cnt         <= 3'd0;
        end else begin
            r_state         <= w_state_next;
            r_reader_resetn <= (w_state_next == FETCH_STATE_STREAM);
            r_frame_done    <= w_frame_done_next;
            if (w_retry_clr)      r_retry_cnt <= 3'd0;
            else if (w_retry_inc) r_retry_cnt <= r_retry_cnt + 3'd1;
            if (w_frame_done_next) r_frame_done_sticky <= 1'b1;
            else if (w_latch)      r_frame_done_sticky <= 1'b0;
            if (w_state_next == FETCH_STATE_ERROR) r_error_sticky <= 1'b1;
            else if (w_latch)                      r_error_sticky <= 1'b0;
        end
    end

    always_comb begin
        w_status                   = '0;
        w_status.retry_cnt         = r_retry_cnt;
        w_status.busy              = (r_state != FETCH_STATE_IDLE) &&
                                     (r_state != FETCH_STATE_DONE) &&
                                     (r_state != FETCH_STATE_ERROR);
        w_status.error             = r_error_sticky;
        w_status.frame_done_sticky = r_frame_done_sticky;
        w_status.state             = r_state;
    end

    assign o_wire_state                         = w_status;
    assign o_wire_frame_done                    = r_frame_done;
    assign io_wire_reader.o_wire_reader_address = w_burst_address;
    assign io_wire_reader.o_wire_reader_length  = w_burst_length;
    assign io_wire_reader.o_wire_reader_resetn  = r_reader_resetn;

endmodule
`default_nettype wire
